// File: rtl/duck_hunt_pkg.sv
// Shared duck-hunt types: FSM encodings, screen geometry, position width.
// Also holds the 13-bit box-span helper used by the shot hit test.
package duck_hunt_pkg;

    localparam int POS_W      = 12;
    localparam int SCREEN_W   = 1024;
    localparam int SCREEN_H   = 768;
    localparam int DUCK_W_DEF = 64;
    localparam int DUCK_H_DEF = 64;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_FLASH,
        ST_COOLDOWN,
        ST_EMPTY
    } state_t;

    // One extra bit so lo+w never wraps near the top of the range
    function automatic logic in_span(pos_t p, pos_t lo, int unsigned w);
        logic [POS_W:0] p13;
        logic [POS_W:0] lo13;
        logic [POS_W:0] hi13;
        p13  = {1'b0, p};
        lo13 = {1'b0, lo};
        hi13 = lo13 + (POS_W+1)'(w);
        return (p13 >= lo13) && (p13 < hi13);
    endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Button front end: optional debounce, then rising-edge detect.
// SHOT_CTL_DEBOUNCE_EN enables the stable-level filter.
module btn_edge_det #(
    parameter int DEBOUNCE_CYCLES = 65_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press_pulse
);

    logic level;
    logic prev;

`ifdef SHOT_CTL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Level starts high so a button held through reset stays silent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (btn == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= btn;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    logic unused_db;

    assign level     = btn;
    assign unused_db = (DEBOUNCE_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= level;
    end

    assign press_pulse = level & ~prev;

endmodule

// File: rtl/shot_ctl.sv
// Trigger controller: click -> shot, hit test, ammo, flash/cooldown timing.
// Build with SHOT_CTL_DEBOUNCE_EN to debounce mouse_left.
module shot_ctl
    import duck_hunt_pkg::*;
#(
    parameter int DUCK_W          = DUCK_W_DEF,
    parameter int DUCK_H          = DUCK_H_DEF,
    parameter int AMMO_MAX        = 3,
    parameter int FLASH_CYCLES    = 1_300_000,
    parameter int COOLDOWN_CYCLES = 6_500_000,
    parameter int DEBOUNCE_CYCLES = 65_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mouse_left,
    input  logic [POS_W-1:0] mouse_xpos,
    input  logic [POS_W-1:0] mouse_ypos,
    input  logic [POS_W-1:0] duck_xpos,
    input  logic [POS_W-1:0] duck_ypos,
    input  logic             duck_active,
    input  logic             round_start,
    output logic             shot_fire,
    output logic             shot_hit,
    output logic             shot_miss,
    output logic [POS_W-1:0] shot_xpos,
    output logic [POS_W-1:0] shot_ypos,
    output logic [1:0]       ammo,
    output logic             flash,
    output logic             busy
);

    localparam int TMAX = (FLASH_CYCLES > COOLDOWN_CYCLES) ?
                          FLASH_CYCLES : COOLDOWN_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nx;

    logic          press;
    logic          accept;
    logic          hit_now;

    logic          fire_nx;
    logic          hit_nx;
    logic          miss_nx;
    logic          flash_nx;
    logic          busy_nx;
    logic [1:0]    ammo_nx;

    btn_edge_det #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (mouse_left),
        .press_pulse(press)
    );

    // A reload on the same cycle as a click drops the click
    assign accept = (state == ST_IDLE) && press &&
                    (ammo != 2'd0) && !round_start;

    assign hit_now = duck_active &&
                     in_span(shot_xpos, duck_xpos, DUCK_W) &&
                     in_span(shot_ypos, duck_ypos, DUCK_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tmr_nx   = (tmr != '0) ? tmr - TW'(1) : tmr;
        unique case (state)
            ST_IDLE: begin
                tmr_nx = '0;
                if (accept) state_nx = ST_EVAL;
            end
            ST_EVAL: begin
                state_nx = ST_FLASH;
                tmr_nx   = TW'(FLASH_CYCLES - 1);
            end
            ST_FLASH: begin
                if (tmr == '0) begin
                    state_nx = ST_COOLDOWN;
                    tmr_nx   = TW'(COOLDOWN_CYCLES - 1);
                end
            end
            ST_COOLDOWN: begin
                if (tmr == '0) begin
                    state_nx = (ammo != 2'd0 || round_start) ?
                               ST_IDLE : ST_EMPTY;
                end
            end
            ST_EMPTY: begin
                tmr_nx = '0;
                if (round_start) state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                tmr_nx   = '0;
            end
        endcase
    end

    always_comb begin
        fire_nx  = accept;
        hit_nx   = (state == ST_EVAL) && hit_now;
        miss_nx  = (state == ST_EVAL) && !hit_now;
        flash_nx = (state_nx == ST_FLASH);
        busy_nx  = (state_nx == ST_EVAL) || (state_nx == ST_FLASH) ||
                   (state_nx == ST_COOLDOWN);
        ammo_nx  = ammo;
        unique case (1'b1)
            round_start: ammo_nx = 2'(AMMO_MAX);
            accept:      ammo_nx = ammo - 2'd1;
            default:     ammo_nx = ammo;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shot_fire <= 1'b0;
            shot_hit  <= 1'b0;
            shot_miss <= 1'b0;
            shot_xpos <= '0;
            shot_ypos <= '0;
            ammo      <= 2'(AMMO_MAX);
            flash     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            shot_fire <= fire_nx;
            shot_hit  <= hit_nx;
            shot_miss <= miss_nx;
            flash     <= flash_nx;
            busy      <= busy_nx;
            ammo      <= ammo_nx;
            if (accept) begin
                shot_xpos <= mouse_xpos;
                shot_ypos <= mouse_ypos;
            end
        end
    end

endmodule
